div_unit: RTL and testbench

//  Multi-cycle radix-2 restoring divider for DIV/DIVU, serving the execute stage.
//  - EX raises start_i and stalls the pipeline until ready_o is high.
//  - EX then writes result_o to HI/LO: HI = remainder, LO = quotient.
//  - Iterative design, one quotient bit per cycle; no combinational divider in the EX path.

---
 rtl/div_unit_pkg.sv | 40 ++++
 rtl/div_unit.sv | 145 ++++++++++++++
 tb/tb_div_unit.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/div_unit_pkg.sv
// Shared state codes, handshake levels and operand helpers for div_unit.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic       DIV_START            = 1'b1;
    localparam logic       DIV_STOP             = 1'b0;
    localparam logic       DIV_RESULT_READY     = 1'b1;
    localparam logic       DIV_RESULT_NOT_READY = 1'b0;
    localparam logic       DIV_SIGNED           = 1'b1;
    localparam logic       DIV_UNSIGNED         = 1'b0;
    localparam logic [5:0] DIV_LAST_CNT         = 6'd32;

    // Magnitude of a two's complement operand; unsigned operands pass through.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        logic [31:0] m;
        if (is_signed && v[31]) begin
            m = (~v) + 32'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

    function automatic logic [31:0] neg_if(input logic [31:0] v, input logic neg);
        logic [31:0] m;
        if (neg) begin
            m = (~v) + 32'd1;
        end else begin
            m = v;
        end
        return m;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Radix-2 restoring divider for DIV/DIVU, one quotient bit per cycle.
// Optional DIV_EARLY_EXIT_EN: finish at once when |dividend| < |divisor|.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    div_state_e  r_state;
    logic [5:0]  r_cnt;
    logic [64:0] r_dividend;
    logic [31:0] r_divisor;
    logic        r_neg_q;
    logic        r_neg_r;
    logic [63:0] r_result;
    logic        r_ready;

    div_state_e  w_state_nxt;
    logic [5:0]  w_cnt_nxt;
    logic [64:0] w_dividend_nxt;
    logic [31:0] w_divisor_nxt;
    logic        w_neg_q_nxt;
    logic        w_neg_r_nxt;
    logic [63:0] w_result_nxt;
    logic        w_ready_nxt;

    logic        w_is_signed;
    logic [31:0] w_op1_mag;
    logic [31:0] w_op2_mag;
    logic [32:0] w_diff;

    assign w_is_signed = (signed_div_i == DIV_SIGNED);
    assign w_op1_mag   = mag32(opdata1_i, w_is_signed);
    assign w_op2_mag   = mag32(opdata2_i, w_is_signed);
    // Trial subtraction; bit 32 set means the partial remainder is smaller than the divisor.
    assign w_diff      = {1'b0, r_dividend[63:32]} - {1'b0, r_divisor};

    // Next-state, datapath and registered-output computation.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_dividend_nxt = r_dividend;
        w_divisor_nxt  = r_divisor;
        w_neg_q_nxt    = r_neg_q;
        w_neg_r_nxt    = r_neg_r;
        w_result_nxt   = 64'd0;
        w_ready_nxt    = DIV_RESULT_NOT_READY;

        case (r_state)
            DIV_FREE: begin
                if ((start_i == DIV_START) && !annul_i) begin
                    w_divisor_nxt = w_op2_mag;
                    w_neg_q_nxt   = w_is_signed & (opdata1_i[31] ^ opdata2_i[31]);
                    w_neg_r_nxt   = w_is_signed & opdata1_i[31];
                    w_cnt_nxt     = 6'd0;
                    if (opdata2_i == 32'd0) begin
                        w_state_nxt = DIV_BYZERO;
                    end
`ifdef DIV_EARLY_EXIT_EN
                    else if (w_op1_mag < w_op2_mag) begin
                        // Quotient is zero and the remainder is the dividend itself.
                        w_dividend_nxt = {opdata1_i, 1'b0, 32'd0};
                        w_state_nxt    = DIV_END;
                    end
`endif
                    else begin
                        w_dividend_nxt = {32'd0, w_op1_mag, 1'b0};
                        w_state_nxt    = DIV_ON;
                    end
                end else begin
                    w_state_nxt = DIV_FREE;
                end
            end
            DIV_BYZERO: begin
                w_dividend_nxt = 65'd0;
                w_state_nxt    = DIV_END;
            end
            DIV_ON: begin
                if (annul_i) begin
                    w_state_nxt = DIV_FREE;
                    w_cnt_nxt   = 6'd0;
                end else if (r_cnt != DIV_LAST_CNT) begin
                    if (w_diff[32]) begin
                        w_dividend_nxt = {r_dividend[63:0], 1'b0};
                    end else begin
                        w_dividend_nxt = {w_diff[31:0], r_dividend[31:0], 1'b1};
                    end
                    w_cnt_nxt = r_cnt + 6'd1;
                end else begin
                    // Remainder follows the dividend's sign.
                    w_dividend_nxt = {neg_if(r_dividend[64:33], r_neg_r), 1'b0,
                                      neg_if(r_dividend[31:0], r_neg_q)};
                    w_cnt_nxt      = 6'd0;
                    w_state_nxt    = DIV_END;
                end
            end
            DIV_END: begin
                if (start_i == DIV_STOP) begin
                    w_state_nxt = DIV_FREE;
                end else begin
                    w_result_nxt = {r_dividend[64:33], r_dividend[31:0]};
                    w_ready_nxt  = DIV_RESULT_READY;
                end
            end
            default: begin
                w_state_nxt = DIV_FREE;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= DIV_FREE;
            r_cnt      <= 6'd0;
            r_dividend <= 65'd0;
            r_divisor  <= 32'd0;
            r_neg_q    <= 1'b0;
            r_neg_r    <= 1'b0;
            r_result   <= 64'd0;
            r_ready    <= DIV_RESULT_NOT_READY;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_dividend <= w_dividend_nxt;
            r_divisor  <= w_divisor_nxt;
            r_neg_q    <= w_neg_q_nxt;
            r_neg_r    <= w_neg_r_nxt;
            r_result   <= w_result_nxt;
            r_ready    <= w_ready_nxt;
        end
    end

    assign result_o = r_result;
    assign ready_o  = r_ready;

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: directed divisions with hand-computed results and latencies.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        signed_div_i = 1'b0;
    logic [31:0] opdata1_i = 32'd0;
    logic [31:0] opdata2_i = 32'd0;
    logic        start_i = 1'b0;
    logic        annul_i = 1'b0;
    logic [63:0] result_o;
    logic        ready_o;

    typedef struct {
        logic [63:0] res;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_ready = 1'b0;

`ifdef DIV_EARLY_EXIT_EN
    localparam int SMALL_LAT = 1;
`else
    localparam int SMALL_LAT = 34;
`endif

    div_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every rising ready_o must match the oldest expected result, on its due cycle.
    always @(negedge clk) begin
        if (!rst && ready_o && !prev_ready) begin
            if (sb.size() == 0) begin
                n_vec = n_vec + 1;
                n_err = n_err + 1;
                $display("FAIL unexpected_ready: result=%h at cycle %0d, none expected", result_o, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                n_vec = n_vec + 1;
                if (result_o !== e.res) begin
                    n_err = n_err + 1;
                    $display("FAIL %s_result: got %h, expected %h", e.name, result_o, e.res);
                end
                n_vec = n_vec + 1;
                if (cyc != e.due) begin
                    n_err = n_err + 1;
                    $display("FAIL %s_latency: ready at cycle %0d, expected %0d", e.name, cyc, e.due);
                end
            end
        end
        prev_ready <= ready_o;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Issue one division, wait for the result, hold it, then drop start or reset.
    task automatic run_div(input string name, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp, input int lat,
                           input int hold, input bit end_rst);
        exp_t e;
        bit   got;
        @(posedge clk); #1;
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        e.res  = exp;
        e.due  = cyc + 1 + lat;
        e.name = name;
        sb.push_back(e);
        @(posedge clk); #1;
        // Operands must be ignored once the division is under way.
        signed_div_i = ~sgn;
        opdata1_i    = ~a;
        opdata2_i    = b ^ 32'h0000_0005;
        got = 1'b0;
        if (ready_o) got = 1'b1;
        for (int i = 0; i < 60 && !got; i++) begin
            @(posedge clk); #1;
            if (ready_o) got = 1'b1;
        end
        if (!got) begin
            n_vec = n_vec + 1;
            n_err = n_err + 1;
            $display("FAIL %s_timeout: ready_o=0 after 60 cycles, expected 1", name);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            chk({name, "_hold_ready"}, {63'd0, ready_o}, 64'd1);
            chk({name, "_hold_result"}, result_o, exp);
        end
        start_i = 1'b0;
        if (end_rst) rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk({name, "_exit_ready"}, {63'd0, ready_o}, 64'd0);
        chk({name, "_exit_result"}, result_o, 64'd0);
    endtask

    initial begin
        bit seen;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ready", {63'd0, ready_o}, 64'd0);
        chk("reset_result", result_o, 64'd0);
        rst = 1'b0;

        run_div("divu_100_7",    1'b0, 32'd100,        32'd7,          {32'h00000002, 32'h0000000E}, 34, 1, 1'b0);
        run_div("div_m7_2",      1'b1, 32'hFFFFFFF9,   32'd2,          {32'hFFFFFFFF, 32'hFFFFFFFD}, 34, 0, 1'b0);
        run_div("div_7_m2",      1'b1, 32'd7,          32'hFFFFFFFE,   {32'h00000001, 32'hFFFFFFFD}, 34, 0, 1'b0);
        run_div("div_m7_m2",     1'b1, 32'hFFFFFFF9,   32'hFFFFFFFE,   {32'hFFFFFFFF, 32'h00000003}, 34, 0, 1'b0);
        run_div("div_m100_7",    1'b1, 32'hFFFFFF9C,   32'd7,          {32'hFFFFFFFE, 32'hFFFFFFF2}, 34, 0, 1'b0);
        run_div("div_ovf",       1'b1, 32'h80000000,   32'hFFFFFFFF,   {32'h00000000, 32'h80000000}, 34, 0, 1'b0);
        run_div("divu_max_1",    1'b0, 32'hFFFFFFFF,   32'd1,          {32'h00000000, 32'hFFFFFFFF}, 34, 0, 1'b0);
        run_div("divu_max_64k",  1'b0, 32'hFFFFFFFF,   32'h00010000,   {32'h0000FFFF, 32'h0000FFFF}, 34, 0, 1'b0);
        run_div("div_min_min",   1'b1, 32'h80000000,   32'h80000000,   {32'h00000000, 32'h00000001}, 34, 0, 1'b0);
        run_div("divu_55_0",     1'b0, 32'd55,         32'd0,          64'd0,                        2,  5, 1'b0);
        run_div("div_m55_0",     1'b1, 32'hFFFFFFC9,   32'd0,          64'd0,                        2,  0, 1'b0);

        // Annul an in-flight division; nothing may come out of it.
        @(posedge clk); #1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd1000;
        opdata2_i    = 32'd3;
        start_i      = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        annul_i = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ready_o) seen = 1'b1;
        end
        chk("annul_no_ready", {63'd0, seen}, 64'd0);
        run_div("divu_9_4",      1'b0, 32'd9,          32'd4,          {32'h00000001, 32'h00000002}, 34, 0, 1'b0);

        run_div("divu_3_10",     1'b0, 32'd3,          32'd10,         {32'h00000003, 32'h00000000}, SMALL_LAT, 0, 1'b0);
        run_div("div_m3_10",     1'b1, 32'hFFFFFFFD,   32'd10,         {32'hFFFFFFFD, 32'h00000000}, SMALL_LAT, 0, 1'b0);

        // Reset mid-computation, then confirm recovery.
        @(posedge clk); #1;
        opdata1_i = 32'd1000;
        opdata2_i = 32'd3;
        start_i   = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        rst     = 1'b1;
        start_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("rst_on_ready", {63'd0, ready_o}, 64'd0);
        chk("rst_on_result", result_o, 64'd0);
        run_div("divu_1000_3",   1'b0, 32'd1000,       32'd3,          {32'h00000001, 32'h0000014D}, 34, 2, 1'b1);

        repeat (3) @(posedge clk);
        #1;
        n_vec = n_vec + 1;
        if (sb.size() != 0) begin
            n_err = n_err + 1;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
